// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared types and sizes for the 4-way round-robin arbiter
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter4_prio_enc4.sv
// rtl/rr_arbiter4_prio_enc4.sv - rotated priority search starting at i_ptr
module prio_enc4
    import rr_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest offset back to i_ptr so the nearest hit wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = i_ptr + IDX_W'(i);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-requester round-robin arbiter with bounded hold and preemption
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    arb_state_t         r_state, w_state;
    logic [IDX_W-1:0]   r_ptr, w_ptr;
    logic [7:0]         r_cnt, w_cnt;
    logic [NUM_REQ-1:0] r_grant, w_grant;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx;
    logic               r_gnt_valid;
    logic               r_preempt, w_preempt;

    logic [NUM_REQ-1:0] w_search;
    logic [IDX_W-1:0]   w_found_idx;
    logic               w_found;
    logic               w_owner_req;
    logic               w_new;

    // While busy the owner is excluded, so the search only sees other requesters.
    assign w_search    = (r_state == ST_IDLE) ? req : (req & ~r_grant);
    assign w_owner_req = |(req & r_grant);

    prio_enc4 u_prio (
        .i_req   (w_search),
        .i_ptr   (r_ptr),
        .o_idx   (w_found_idx),
        .o_found (w_found)
    );

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;
        w_grant   = r_grant;
        w_preempt = 1'b0;
        w_new     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) w_new = 1'b1;
            end
            ST_BUSY: begin
                if (!w_owner_req) begin
                    if (w_found) begin
                        w_new = 1'b1;
                    end else begin
                        w_state = ST_IDLE;
                        w_grant = '0;
                        w_cnt   = '0;
                    end
                end else if (r_cnt < MAX_HOLD_C) begin
                    w_cnt = r_cnt + 8'd1;
                end else if (w_found) begin
                    w_new     = 1'b1;
                    w_preempt = 1'b1;
                end else begin
                    w_cnt = 8'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_grant = '0;
                w_cnt   = '0;
            end
        endcase
        if (w_new) begin
            w_state = ST_BUSY;
            w_grant = NUM_REQ'(1) << w_found_idx;
            w_ptr   = w_found_idx + IDX_W'(1);
            w_cnt   = 8'd1;
        end
    end

    assign w_gnt_idx = {w_grant[2] | w_grant[3], w_grant[1] | w_grant[3]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_cnt       <= w_cnt;
            r_grant     <= w_grant;
            r_gnt_idx   <= w_gnt_idx;
            r_gnt_valid <= |w_grant;
            r_preempt   <= w_preempt;
        end
    end

    assign grant     = r_grant;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed and randomized checks of rr_arbiter4 against a reference model
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_pre   = 1'b0;
    bit m_live  = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int ptr, input int excl);
        for (int j = 0; j < 4; j++) begin
            int k;
            k = (ptr + j) % 4;
            if (r[k] && k != excl) return k;
        end
        return -1;
    endfunction

    // Reference model: owner index, rotation pointer and hold count as plain integers.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_owner = -1; m_ptr = 0; m_cnt = 0; m_pre = 1'b0; m_live = 1'b1;
            end else begin
                int k;
                m_pre = 1'b0;
                if (m_owner < 0) begin
                    k = pick(req, m_ptr, -1);
                    if (k >= 0) begin m_owner = k; m_ptr = (k + 1) % 4; m_cnt = 1; end
                end else if (!req[m_owner]) begin
                    k = pick(req, m_ptr, m_owner);
                    if (k >= 0) begin m_owner = k; m_ptr = (k + 1) % 4; m_cnt = 1; end
                    else begin m_owner = -1; m_cnt = 0; end
                end else if (m_cnt < MAX_HOLD) begin
                    m_cnt++;
                end else begin
                    k = pick(req, m_ptr, m_owner);
                    if (k >= 0) begin m_owner = k; m_ptr = (k + 1) % 4; m_cnt = 1; m_pre = 1'b1; end
                    else m_cnt = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_grant", {28'd0, grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("model_idx", {30'd0, gnt_idx}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
            chk("model_valid", {31'd0, gnt_valid}, {31'd0, m_owner >= 0});
            chk("model_preempt", {31'd0, preempt}, {31'd0, m_pre});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] allr;
        allr = 4'b1111;

        rst_n = 1'b0; req = 4'b0000;
        step(); step();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_idx", {30'd0, gnt_idx}, 32'd0);
        chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
        chk("rst_preempt", {31'd0, preempt}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_grant", {28'd0, grant}, 32'd0);
            chk("idle_valid", {31'd0, gnt_valid}, 32'd0);
        end

        req = 4'b1010; step();
        chk("pair_first_grant", {28'd0, grant}, 32'h2);
        chk("pair_first_idx", {30'd0, gnt_idx}, 32'd1);
        req = 4'b1000; step();
        chk("pair_next_grant", {28'd0, grant}, 32'h8);
        chk("pair_next_idx", {30'd0, gnt_idx}, 32'd3);
        req = 4'b0000; step();
        chk("pair_release", {28'd0, grant}, 32'd0);

        req = 4'b1111; step();
        chk("rr_start", {28'd0, grant}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            req = allr & ~(4'b0001 << k);
            step();
            chk("rr_order", {28'd0, grant}, 32'd1 << ((k + 1) % 4));
            req = 4'b1111;
        end
        req = 4'b0000; step(); step();

        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b0011; step();
        chk("hold_start", {28'd0, grant}, 32'h1);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step();
            chk("hold_owner0", {28'd0, grant}, 32'h1);
            chk("hold_no_pre", {31'd0, preempt}, 32'd0);
        end
        step();
        chk("expiry_grant", {28'd0, grant}, 32'h2);
        chk("expiry_preempt", {31'd0, preempt}, 32'd1);
        step();
        chk("expiry_pulse_end", {31'd0, preempt}, 32'd0);
        req = 4'b0000; step(); step();

        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("solo_grant", {28'd0, grant}, 32'h4);
            chk("solo_no_pre", {31'd0, preempt}, 32'd0);
        end
        req = 4'b0000; step(); step();

        req = 4'b1000; step();
        chk("pre_rst_grant", {28'd0, grant}, 32'h8);
        rst_n = 1'b0; step();
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        rst_n = 1'b1; step();
        chk("post_rst_grant", {28'd0, grant}, 32'h8);
        chk("post_rst_idx", {30'd0, gnt_idx}, 32'd3);

        // Sticky random requests so owners hold long enough to reach expiry.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-low.
REQ-002 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles per owner (legal range 2..255).
REQ-003 Port clk  input  1  SHALL be the single rising-edge clock.
REQ-004 Port rst_n  input  1  SHALL be the synchronous active-low reset.
REQ-005 Port req  input  4  SHALL carry per-requester requests; bit i is held high while requester i wants the shared resource.
REQ-006 Port grant  output  4  SHALL be the one-hot (or zero) grant vector.
REQ-007 Port gnt_idx  output  2  SHALL be the binary index of the granted requester (encoded from grant).
REQ-008 Port gnt_valid  output  1  SHALL be high exactly when grant is non-zero.
REQ-009 Port preempt  output  1  SHALL pulse high for one cycle when a grant is forcibly moved by MAX_HOLD expiry.

Function
REQ-010 States SHALL be IDLE (no owner) and BUSY (one owner); all outputs are registered.
REQ-011 Round-robin pointer ptr[1:0] SHALL hold the highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-012 IDLE with req != 0 at edge N SHALL yield BUSY with grant to first requester in search order at edge N+1 (1-cycle latency).
REQ-013 IDLE with req == 0 SHALL remain IDLE, grant = 0.
REQ-014 On every new grant to index k, ptr SHALL become k+1 mod 4 and hold counter SHALL load 1.
REQ-015 BUSY: while req[owner] stays high and hold counter < MAX_HOLD, grant SHALL be unchanged and counter SHALL increment.
REQ-016 BUSY: when req[owner] drops, next edge SHALL grant the next requester in search order among remaining requests (back-to-back, no dead cycle), or go IDLE if none.
REQ-017 BUSY: when counter == MAX_HOLD and req[owner] high and another request exists, next edge SHALL grant the next other requester and pulse preempt.
REQ-018 BUSY: when counter == MAX_HOLD and no other request exists, owner SHALL keep grant, counter SHALL reload 1, preempt SHALL stay low.
REQ-019 Simultaneous release by owner and expiry SHALL be treated as release (REQ-016), preempt low.
REQ-020 grant SHALL never have more than one bit set; gnt_idx SHALL equal 0 when gnt_valid is low.
REQ-021 Request bits rising or falling for non-owners SHALL not affect the current grant.

Reset
REQ-022 With rst_n low at a clock edge: state = IDLE, grant = 0, gnt_idx = 0, gnt_valid = 0, preempt = 0, ptr = 0, counter = 0.
REQ-023 Reset asserted mid-grant SHALL drop grant at that edge; the first post-reset grant SHALL follow REQ-012 with ptr = 0.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE, BUSY), NUM_REQ = 4, and IDX_W = 2.
REQ-025 One sub-module, prio_enc4, SHALL implement the rotated 4-input priority search returning index and found flag; grant-to-index encoding SHALL be combinational OR logic.

Verification
REQ-026 Reset then req=4'b0000 for 5 cycles -> grant=0, gnt_valid=0 throughout.
REQ-027 req=4'b1010 from IDLE, ptr=0 -> next cycle grant=4'b0010, gnt_idx=1; drop req[1] -> next cycle grant=4'b1000, gnt_idx=3.
REQ-028 req=4'b1111 held, each owner drops req after 2 cycles then reasserts -> grant order 0,1,2,3,0.
REQ-029 MAX_HOLD=8, req=4'b0011 held -> owner 0 for 8 cycles, then grant=4'b0010 with preempt=1 for one cycle.
REQ-030 MAX_HOLD=8, req=4'b0100 alone for 20 cycles -> grant=4'b0100 continuously, preempt never high.
REQ-031 rst_n low for one cycle while grant=4'b1000 -> grant=0 next edge; with req=4'b1000 still high, grant=4'b1000 one cycle after rst_n rises.
